// File: rtl/regfile_param.sv
// Parametrised register file: NT temporaries and NR general registers with masked clear/load/dec/inc,
// half-word load and sticky wrap flags. Define REGFILE_BYPASS_EN to forward next-edge values to o1/o2.
module regfile_param #(
   parameter  int W    = 8,
   parameter  int NR   = 4,
   parameter  int NT   = 4,
   localparam int SELW = $clog2(NR + NT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    load,
   input  logic [1:0]      funsel,
   input  logic            half,
   input  logic            lh,
   input  logic [NR-1:0]   rsel,
   input  logic [NT-1:0]   tsel,
   input  logic [SELW-1:0] o1sel,
   input  logic [SELW-1:0] o2sel,
   output logic [W-1:0]    o1,
   output logic [W-1:0]    o2,
   output logic [NT+NR-1:0] wrap
);

   localparam int N  = NT + NR;
   localparam int HW = W / 2;

   // Storage index map matches the read selects: T[i] at i, R[j] at NT+j.
   logic [N-1:0] mask_s;
   logic [W-1:0] regs_q [N];
   logic [W-1:0] regs_d [N];
   logic [W-1:0] rd_s   [N];
   logic [N-1:0] wrap_q;
   logic [N-1:0] wrap_d;

   assign mask_s = {rsel, tsel};
   assign wrap   = wrap_q;

   function automatic logic [W-1:0] next_val(input logic [W-1:0] old, input logic [1:0] f,
                                             input logic h, input logic l, input logic [W-1:0] d);
      logic [W-1:0] r;
      case (f)
         2'b00:   r = '0;
         2'b01: begin
            if (!h)     r = d;
            else if (l) r = {d[HW-1:0], old[HW-1:0]};
            else        r = {old[W-1:HW], d[HW-1:0]};
         end
         2'b10:   r = old - W'(1);
         2'b11:   r = old + W'(1);
         default: r = old;
      endcase
      return r;
   endfunction

   function automatic logic next_wrap(input logic [W-1:0] old, input logic [1:0] f, input logic w);
      logic r;
      case (f)
         2'b00:   r = 1'b0;
         2'b10:   r = w | (old == '0);
         2'b11:   r = w | (old == {W{1'b1}});
         default: r = w;
      endcase
      return r;
   endfunction

   // Next-state for every register; rst zeroes the value that would be forwarded.
   always_comb begin
      wrap_d = wrap_q;
      for (int i = 0; i < N; i++) begin
         regs_d[i] = regs_q[i];
         if (rst) begin
            regs_d[i] = '0;
            wrap_d[i] = 1'b0;
         end else if (mask_s[i]) begin
            regs_d[i] = next_val(regs_q[i], funsel, half, lh, load);
            wrap_d[i] = next_wrap(regs_q[i], funsel, wrap_q[i]);
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) regs_q[i] <= '0;
         wrap_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
         wrap_q <= wrap_d;
      end
   end

   // Read source: forwarded next value or stored value.
   always_comb begin
      for (int i = 0; i < N; i++) begin
`ifdef REGFILE_BYPASS_EN
         rd_s[i] = regs_d[i];
`else
         rd_s[i] = regs_q[i];
`endif
      end
   end

   // Read muxes; indices beyond N-1 match no entry and read zero.
   always_comb begin
      o1 = '0;
      o2 = '0;
      for (int i = 0; i < N; i++) begin
         if (o1sel == SELW'(i)) o1 = rd_s[i];
         else                   o1 = o1;
         if (o2sel == SELW'(i)) o2 = rd_s[i];
         else                   o2 = o2;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (W=8, NR=4, NT=4, plus an NR=3 instance for unmapped reads).
module tb_regfile_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] load;
   logic [1:0] funsel;
   logic       half, lh;
   logic [3:0] rsel, tsel;
   logic [2:0] o1sel, o2sel;
   logic [7:0] o1, o2;
   logic [7:0] wrap;

   logic       rst3;
   logic [7:0] load3;
   logic [1:0] funsel3;
   logic [2:0] rsel3;
   logic [3:0] tsel3;
   logic [2:0] o1sel3, o2sel3;
   logic [7:0] o13, o23;
   logic [6:0] wrap3;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_r [4];
   logic [7:0] m_t [4];
   logic       m_wr [4];
   logic       m_wt [4];

   always #5 clk = ~clk;

   regfile_param #(.W(8), .NR(4), .NT(4)) dut (
      .clk(clk), .rst(rst), .load(load), .funsel(funsel), .half(half), .lh(lh),
      .rsel(rsel), .tsel(tsel), .o1sel(o1sel), .o2sel(o2sel), .o1(o1), .o2(o2), .wrap(wrap));

   regfile_param #(.W(8), .NR(3), .NT(4)) dut3 (
      .clk(clk), .rst(rst3), .load(load3), .funsel(funsel3), .half(1'b0), .lh(1'b0),
      .rsel(rsel3), .tsel(tsel3), .o1sel(o1sel3), .o2sel(o2sel3), .o1(o13), .o2(o23), .wrap(wrap3));

   function automatic logic [7:0] mdl_val(input logic [7:0] old, input logic [1:0] f,
                                         input logic h, input logic l, input logic [7:0] d);
      int v = int'(old);
      int x = int'(d);
      case (f)
         2'b00: return 8'h00;
         2'b01: begin
            if (!h)     return d;
            else if (l) return 8'((x % 16) * 16 + v % 16);
            else        return 8'((v / 16) * 16 + x % 16);
         end
         2'b10:   return 8'((v + 255) % 256);
         default: return 8'((v + 1) % 256);
      endcase
   endfunction

   function automatic logic mdl_wrap(input logic [7:0] old, input logic [1:0] f, input logic w);
      if (f == 2'b00) return 1'b0;
      if (f == 2'b10 && old == 8'h00) return 1'b1;
      if (f == 2'b11 && old == 8'hFF) return 1'b1;
      return w;
   endfunction

   function automatic logic [7:0] mdl_read(input int idx);
      if (idx < 4) return m_t[idx];
      if (idx < 8) return m_r[idx - 4];
      return 8'h00;
   endfunction

   function automatic logic [7:0] mdl_wrapvec();
      logic [7:0] v;
      for (int i = 0; i < 4; i++) begin
         v[i]     = m_wt[i];
         v[i + 4] = m_wr[i];
      end
      return v;
   endfunction

   task automatic model_apply(input logic r, input logic [1:0] f, input logic h, input logic l,
                              input logic [7:0] d, input logic [3:0] rs, input logic [3:0] ts);
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            m_r[i] = 8'h00; m_t[i] = 8'h00; m_wr[i] = 1'b0; m_wt[i] = 1'b0;
         end else begin
            if (rs[i]) begin
               m_wr[i] = mdl_wrap(m_r[i], f, m_wr[i]);
               m_r[i]  = mdl_val(m_r[i], f, h, l, d);
            end
            if (ts[i]) begin
               m_wt[i] = mdl_wrap(m_t[i], f, m_wt[i]);
               m_t[i]  = mdl_val(m_t[i], f, h, l, d);
            end
         end
      end
   endtask

   // Called at a falling edge: drive, take one rising edge, return at the next falling edge idle.
   task automatic step(input logic r, input logic [1:0] f, input logic h, input logic l,
                       input logic [7:0] d, input logic [3:0] rs, input logic [3:0] ts);
      rst = r; funsel = f; half = h; lh = l; load = d; rsel = rs; tsel = ts;
      @(posedge clk);
      model_apply(r, f, h, l, d, rs, ts);
      @(negedge clk);
      rst = 1'b0; funsel = 2'b00; half = 1'b0; lh = 1'b0; rsel = 4'b0000; tsel = 4'b0000;
   endtask

   task automatic test_reset();
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'h5A, 4'b1111, 4'b1111);
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'hFF, 4'b0000, 4'b0001);
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0001);
      o1sel = 3'd0; #1;
      total++;
      if (wrap !== 8'h01) begin bad++; $display("FAIL preload_wrap: got %h expected 01", wrap); end
      step(1'b1, 2'b01, 1'b0, 1'b0, 8'hFF, 4'b1111, 4'b1111);
      for (int i = 0; i < 8; i++) begin
         o1sel = 3'(i); o2sel = 3'(7 - i); #1;
         total++;
         if (o1 !== 8'h00 || o2 !== 8'h00) begin
            bad++; $display("FAIL reset_regs[%0d]: got o1=%h o2=%h expected 00", i, o1, o2);
         end
      end
      total++;
      if (wrap !== 8'h00) begin bad++; $display("FAIL reset_wrap: got %h expected 00", wrap); end
   endtask

   task automatic test_multi_load();
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'h95, 4'b0100, 4'b0001);
      o1sel = 3'd6; o2sel = 3'd0; #1;
      total++;
      if (o1 !== 8'h95 || o2 !== 8'h95) begin
         bad++; $display("FAIL multi_load: got o1=%h o2=%h expected 95", o1, o2);
      end
      for (int i = 0; i < 8; i++) begin
         o1sel = 3'(i); #1;
         total++;
         if (o1 !== mdl_read(i)) begin
            bad++; $display("FAIL multi_load_others[%0d]: got %h expected %h", i, o1, mdl_read(i));
         end
      end
   endtask

   task automatic test_inc_wrap();
      o1sel = 3'd1;
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'hFF, 4'b0000, 4'b0010);
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0010);
      #1; total++;
      if (o1 !== 8'h00 || wrap[1] !== 1'b1) begin
         bad++; $display("FAIL inc_wrap: got %h/%b expected 00/1", o1, wrap[1]);
      end
      step(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0010);
      #1; total++;
      if (o1 !== 8'h01 || wrap[1] !== 1'b1) begin
         bad++; $display("FAIL inc_sticky: got %h/%b expected 01/1", o1, wrap[1]);
      end
      step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0010);
      #1; total++;
      if (o1 !== 8'h00 || wrap[1] !== 1'b0) begin
         bad++; $display("FAIL inc_clear: got %h/%b expected 00/0", o1, wrap[1]);
      end
   endtask

   task automatic test_dec_wrap();
      o1sel = 3'd4;
      step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 4'b0001, 4'b0000);
      step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 4'b0001, 4'b0000);
      #1; total++;
      if (o1 !== 8'hFF || wrap[4] !== 1'b1) begin
         bad++; $display("FAIL dec_wrap: got %h/%b expected ff/1", o1, wrap[4]);
      end
      step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 4'b0001, 4'b0000);
      #1; total++;
      if (o1 !== 8'hFE || wrap[4] !== 1'b1) begin
         bad++; $display("FAIL dec_second: got %h/%b expected fe/1", o1, wrap[4]);
      end
   endtask

   task automatic test_half_load();
      o1sel = 3'd5;
      step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b0000);
      step(1'b0, 2'b01, 1'b1, 1'b1, 8'h0A, 4'b0010, 4'b0000);
      #1; total++;
      if (o1 !== 8'hA0) begin bad++; $display("FAIL half_upper: got %h expected a0", o1); end
      step(1'b0, 2'b01, 1'b1, 1'b0, 8'h05, 4'b0010, 4'b0000);
      #1; total++;
      if (o1 !== 8'hA5) begin bad++; $display("FAIL half_lower: got %h expected a5", o1); end
      step(1'b0, 2'b11, 1'b1, 1'b0, 8'h00, 4'b0010, 4'b0000);
      #1; total++;
      if (o1 !== 8'hA6) begin bad++; $display("FAIL half_ignored_inc: got %h expected a6", o1); end
   endtask

   task automatic test_bypass();
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 4'b1000, 4'b0000);
      o1sel = 3'd7;
      rsel = 4'b1000; funsel = 2'b01; load = 8'h3C; #1;
      total++;
`ifdef REGFILE_BYPASS_EN
      if (o1 !== 8'h3C) begin bad++; $display("FAIL bypass_before: got %h expected 3c", o1); end
`else
      if (o1 !== 8'h11) begin bad++; $display("FAIL bypass_before: got %h expected 11", o1); end
`endif
      @(posedge clk);
      model_apply(1'b0, 2'b01, 1'b0, 1'b0, 8'h3C, 4'b1000, 4'b0000);
      @(negedge clk);
      rsel = 4'b0000; funsel = 2'b00; #1;
      total++;
      if (o1 !== 8'h3C) begin bad++; $display("FAIL bypass_after: got %h expected 3c", o1); end
      rst = 1'b1; #1;
      total++;
`ifdef REGFILE_BYPASS_EN
      if (o1 !== 8'h00) begin bad++; $display("FAIL bypass_rst: got %h expected 00", o1); end
`else
      if (o1 !== 8'h3C) begin bad++; $display("FAIL bypass_rst: got %h expected 3c", o1); end
`endif
      @(posedge clk);
      model_apply(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_out_of_range();
      rst3 = 1'b0; rsel3 = 3'b111; tsel3 = 4'b1111; funsel3 = 2'b01; load3 = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      rsel3 = 3'b000; tsel3 = 4'b0000; funsel3 = 2'b00;
      o1sel3 = 3'd7; o2sel3 = 3'd6; #1;
      total++;
      if (o13 !== 8'h00) begin bad++; $display("FAIL unmapped_read: got %h expected 00", o13); end
      total++;
      if (o23 !== 8'hFF) begin bad++; $display("FAIL last_mapped_read: got %h expected ff", o23); end
   endtask

   task automatic test_random();
      logic       r, h, l;
      logic [1:0] f;
      logic [7:0] d;
      logic [3:0] rs, ts;
      for (int n = 0; n < 300; n++) begin
         r  = ($urandom_range(0, 19) == 0);
         f  = 2'($urandom_range(0, 3));
         h  = 1'($urandom_range(0, 1));
         l  = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         rs = 4'($urandom);
         ts = 4'($urandom);
         if (n % 8 == 0) begin
            d = 8'hFF; f = 2'b01; h = 1'b0;
         end
         step(r, f, h, l, d, rs, ts);
         o1sel = 3'($urandom_range(0, 7)); o2sel = 3'($urandom_range(0, 7)); #1;
         total++;
         if (o1 !== mdl_read(int'(o1sel)) || o2 !== mdl_read(int'(o2sel)) || wrap !== mdl_wrapvec()) begin
            bad++;
            $display("FAIL random[%0d]: got o1=%h o2=%h wrap=%h expected o1=%h o2=%h wrap=%h", n,
                     o1, o2, wrap, mdl_read(int'(o1sel)), mdl_read(int'(o2sel)), mdl_wrapvec());
         end
      end
   endtask

   task automatic test_back_to_back();
      o1sel = 3'd2;
      step(1'b0, 2'b01, 1'b0, 1'b0, 8'hFD, 4'b0000, 4'b0100);
      rsel = 4'b0000; tsel = 4'b0100; funsel = 2'b11;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk);
         model_apply(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0100);
         @(negedge clk);
         tsel = 4'b0000; #1;
         total++;
         if (o1 !== mdl_read(2) || wrap[2] !== m_wt[2]) begin
            bad++; $display("FAIL back_to_back[%0d]: got %h/%b expected %h/%b", n, o1, wrap[2], mdl_read(2), m_wt[2]);
         end
         tsel = 4'b0100;
      end
      tsel = 4'b0000; funsel = 2'b00;
   endtask

   initial begin
      rst = 1'b1; load = 8'h00; funsel = 2'b00; half = 1'b0; lh = 1'b0;
      rsel = 4'b0000; tsel = 4'b0000; o1sel = 3'd0; o2sel = 3'd0;
      rst3 = 1'b1; load3 = 8'h00; funsel3 = 2'b00; rsel3 = 3'b000; tsel3 = 4'b0000;
      o1sel3 = 3'd0; o2sel3 = 3'd0;
      for (int i = 0; i < 4; i++) begin
         m_r[i] = 8'h00; m_t[i] = 8'h00; m_wr[i] = 1'b0; m_wt[i] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_multi_load();
      test_inc_wrap();
      test_dec_wrap();
      test_half_load();
      test_bypass();
      test_out_of_range();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file that generalises the fixed 8-bit, 4+4 register bank. It provides NR general and NT temporary registers of width W, two combinational read ports, one-hot multi-register write masks, a clear/load/decrement/increment function select, half-word loading, and sticky per-register wrap flags. It sits between the ALU result bus and the ALU operand muxes of the datapath.

## Interface
Parameters:
- W, 8, register width; even, ≥ 2
- NR, 4, number of general registers R[0..NR-1]
- NT, 4, number of temporary registers T[0..NT-1]
- SELW, derived as clog2(NR+NT), read-select width; local, not overridable

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- load  in  W  write data
- funsel  in  2  function select: 00 clear, 01 load, 10 decrement, 11 increment
- half  in  1  with funsel=01, load only one half of the register
- lh  in  1  half select when half=1: 1 = upper half, 0 = lower half
- rsel  in  NR  one-hot-or-multi write mask for R; bit i enables R[i]
- tsel  in  NT  write mask for T; bit i enables T[i]
- o1sel, o2sel  in  SELW each  read selects: index i<NT selects T[i]; NT≤i<NT+NR selects R[i-NT]; any other index reads 0
- o1, o2  out  W each  read data
- wrap  out  NT+NR  sticky wrap flags, same index map as o1sel

## Operation
- A register is written only if its mask bit is set. With no mask bits set, no state changes.
- Every selected register performs the same function in the same cycle.
- 00: register ← 0; its wrap flag ← 0.
- 01, half=0: register ← load.
- 01, half=1, lh=1: upper W/2 bits ← load[W/2-1:0]; lower half is kept.
- 01, half=1, lh=0: lower W/2 bits ← load[W/2-1:0]; upper half is kept.
- 10: register ← register − 1, modulo 2^W. If the old value was 0, the result is all-ones and the wrap flag is set.
- 11: register ← register + 1, modulo 2^W. If the old value was all-ones, the result is 0 and the wrap flag is set.
- Wrap flags are sticky. They clear only on rst or on a clear (00) of that register; load does not clear them.
- half and lh are ignored unless funsel=01.
- Reads are combinational from the current register state. o1 and o2 may select the same register.

## Timing
- Reset:
  - rst=1 at a rising edge sets all registers and all wrap bits to 0.
  - From that edge, o1=o2=0 and wrap=0.
  - rst has priority over any funsel or mask in the same cycle.
  - A rst mid-sequence discards the pending operation.
- Write latency: 1 cycle. The new value is visible on o1/o2 after the edge.
- Read latency: 0 cycles, combinational from select to output.
- Back-to-back increments: one step per enabled edge, with no bubbles.
- Unselected registers hold their value indefinitely.

## Configuration
- REGFILE_BYPASS_EN defined:
  - o1/o2 forward the value a selected register will take at the next edge whenever its mask bit is set in the current cycle.
  - This covers all functions, including half load.
  - rst=1 forces the forwarded value to 0.
- REGFILE_BYPASS_EN undefined:
  - o1/o2 always show the stored value.
  - A write appears one cycle later.

## Test plan
All scenarios use W=8, NR=4, NT=4.
- Reset: preload values, assert rst for one edge with funsel=01, load=0xFF and all masks set -> all registers 0x00, wrap=0x00, o1=o2=0x00.
- Multi-load: load=0x95, rsel=0100, tsel=0001, funsel=01, one edge -> R2=T0=0x95; o1sel=6 gives o1=0x95; o2sel=0 gives o2=0x95; other registers remain 0.
- Increment wrap: load T1=0xFF, then funsel=11 with tsel=0010 for one edge -> T1=0x00, wrap[1]=1. A further increment gives 0x01 and wrap[1] stays 1. funsel=00 then gives T1=0x00, wrap[1]=0.
- Decrement wrap: R0=0x00, funsel=10, rsel=0001 -> R0=0xFF, wrap[4]=1. A second decrement gives 0xFE.
- Half load: R1=0x00; half=1, lh=1, load=0x0A -> R1=0xA0. Then lh=0, load=0x05 -> R1=0xA5. half=1 with funsel=11 -> R1=0xA6.
- Bypass: o1sel=7, R3=0x11; rsel=1000, funsel=01, load=0x3C before the edge.
  - With REGFILE_BYPASS_EN: o1=0x3C before the edge.
  - Without it: o1=0x11 before the edge and 0x3C after.
  - o1sel=7 with only NT+NR=7 configured (NR=3) -> o1=0x00.
